// File: rtl/vga_sync_gen.sv
// Raster timing generator: free-running line/frame counters with a registered
// decode stage, so every output lags the counters by exactly one pixel clock.
module vga_sync_gen #(
  parameter int H_SYNC  = 128,
  parameter int H_BACK  = 88,
  parameter int H_ACT   = 800,
  parameter int H_FRONT = 40,
  parameter int V_SYNC  = 4,
  parameter int V_BACK  = 23,
  parameter int V_ACT   = 600,
  parameter int V_FRONT = 1,
  parameter bit H_POL   = 1'b1,
  parameter bit V_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        hsync,
  output logic        vsync,
  output logic        ready,
  output logic [10:0] x_addr,
  output logic [10:0] y_addr,
  output logic        frame_start
);

  localparam int HT = H_SYNC + H_BACK + H_ACT + H_FRONT;
  localparam int VT = V_SYNC + V_BACK + V_ACT + V_FRONT;
  localparam int HS = H_SYNC + H_BACK;
  localparam int VS = V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST    = 11'(HT - 1);
  localparam logic [10:0] V_LAST    = 11'(VT - 1);
  localparam logic [10:0] H_SYNC_END = 11'(H_SYNC);
  localparam logic [10:0] V_SYNC_END = 11'(V_SYNC);
  localparam logic [10:0] H_ACT_BEG = 11'(HS);
  localparam logic [10:0] H_ACT_END = 11'(HS + H_ACT);
  localparam logic [10:0] V_ACT_BEG = 11'(VS);
  localparam logic [10:0] V_ACT_END = 11'(VS + V_ACT);

  logic [10:0] h_cnt_reg;
  logic [10:0] v_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (h_cnt_reg == H_LAST) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= (v_cnt_reg == V_LAST) ? 11'd0 : v_cnt_reg + 11'd1;
    end else begin
      h_cnt_reg <= h_cnt_reg + 11'd1;
    end
  end

  logic        hsync_next;
  logic        vsync_next;
  logic        act_next;
  logic [10:0] x_next;
  logic [10:0] y_next;
  logic        frame_start_next;

  always_comb begin
    hsync_next       = (h_cnt_reg < H_SYNC_END) ? H_POL : ~H_POL;
    vsync_next       = (v_cnt_reg < V_SYNC_END) ? V_POL : ~V_POL;
    act_next         = (h_cnt_reg >= H_ACT_BEG) && (h_cnt_reg < H_ACT_END) &&
                       (v_cnt_reg >= V_ACT_BEG) && (v_cnt_reg < V_ACT_END);
    x_next           = act_next ? (h_cnt_reg - H_ACT_BEG) : 11'd0;
    y_next           = act_next ? (v_cnt_reg - V_ACT_BEG) : 11'd0;
    frame_start_next = (h_cnt_reg == 11'd0) && (v_cnt_reg == 11'd0);
  end

  // Outputs reset on the same edge as the counters, so a mid-frame reset
  // drops the partial frame without any stray ready/frame_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      ready       <= 1'b0;
      x_addr      <= '0;
      y_addr      <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      ready       <= act_next;
      x_addr      <= x_next;
      y_addr      <= y_next;
      frame_start <= frame_start_next;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: two small-timing builds driven by a shared random
// reset, compared every clock against an arithmetic raster model.
module tb_vga_sync_gen;

  typedef struct {
    int hsync, hback, hact, hfront;
    int vsync, vback, vact, vfront;
    bit hpol, vpol;
  } tim_t;

  typedef struct {
    logic        hs, vs, rd, fs;
    logic [10:0] x, y;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        hs0, vs0, rd0, fs0, hs1, vs1, rd1, fs1;
  logic [10:0] x0, y0, x1, y1;

  vga_sync_gen #(
    .H_SYNC(2), .H_BACK(2), .H_ACT(4), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_ACT(3), .V_FRONT(1),
    .H_POL(1'b1), .V_POL(1'b1)
  ) dut_s (
    .clk(clk), .rst(rst), .hsync(hs0), .vsync(vs0), .ready(rd0),
    .x_addr(x0), .y_addr(y0), .frame_start(fs0)
  );

  vga_sync_gen #(
    .H_SYNC(5), .H_BACK(3), .H_ACT(9), .H_FRONT(4),
    .V_SYNC(2), .V_BACK(3), .V_ACT(5), .V_FRONT(2),
    .H_POL(1'b0), .V_POL(1'b1)
  ) dut_m (
    .clk(clk), .rst(rst), .hsync(hs1), .vsync(vs1), .ready(rd1),
    .x_addr(x1), .y_addr(y1), .frame_start(fs1)
  );

  tim_t cfg [2];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic out_t observe(input int d);
    out_t o;
    if (d == 0) begin
      o.hs = hs0; o.vs = vs0; o.rd = rd0; o.fs = fs0; o.x = x0; o.y = y0;
    end else begin
      o.hs = hs1; o.vs = vs1; o.rd = rd1; o.fs = fs1; o.x = x1; o.y = y1;
    end
    return o;
  endfunction

  function automatic int htot(input tim_t c);
    return c.hsync + c.hback + c.hact + c.hfront;
  endfunction

  function automatic int vtot(input tim_t c);
    return c.vsync + c.vback + c.vact + c.vfront;
  endfunction

  // Expected outputs t pixel clocks after the raster started at (0,0).
  function automatic out_t model(input tim_t c, input int t);
    out_t e;
    int h, v, hs, vs;
    bit act;
    h  = t % htot(c);
    v  = (t / htot(c)) % vtot(c);
    hs = c.hsync + c.hback;
    vs = c.vsync + c.vback;
    act  = (h >= hs) && (h < hs + c.hact) && (v >= vs) && (v < vs + c.vact);
    e.hs = (h < c.hsync) ? c.hpol : ~c.hpol;
    e.vs = (v < c.vsync) ? c.vpol : ~c.vpol;
    e.rd = act;
    e.x  = act ? 11'(h - hs) : 11'd0;
    e.y  = act ? 11'(v - vs) : 11'd0;
    e.fs = (h == 0) && (v == 0);
    return e;
  endfunction

  function automatic out_t reset_vals(input tim_t c);
    out_t e;
    e.hs = ~c.hpol; e.vs = ~c.vpol; e.rd = 1'b0; e.fs = 1'b0;
    e.x  = '0;      e.y  = '0;
    return e;
  endfunction

  task automatic compare(input int d, input int cyc, input out_t o, input out_t e);
    check($sformatf("d%0d c%0d hsync", d, cyc), 32'(o.hs), 32'(e.hs));
    check($sformatf("d%0d c%0d vsync", d, cyc), 32'(o.vs), 32'(e.vs));
    check($sformatf("d%0d c%0d ready", d, cyc), 32'(o.rd), 32'(e.rd));
    check($sformatf("d%0d c%0d x_addr", d, cyc), 32'(o.x), 32'(e.x));
    check($sformatf("d%0d c%0d y_addr", d, cyc), 32'(o.y), 32'(e.y));
    check($sformatf("d%0d c%0d frame_start", d, cyc), 32'(o.fs), 32'(e.fs));
  endtask

  initial begin
    int   n;
    bit   rst_v, directed_done;
    int   directed_at;
    bit   run_valid [2];
    int   ready_cnt [2];
    int   period    [2];
    out_t o;

    cfg[0] = '{hsync:2, hback:2, hact:4, hfront:2, vsync:1, vback:1, vact:3, vfront:1,
               hpol:1'b1, vpol:1'b1};
    cfg[1] = '{hsync:5, hback:3, hact:9, hfront:4, vsync:2, vback:3, vact:5, vfront:2,
               hpol:1'b0, vpol:1'b1};

    // Mid-frame reset point: dut_m at x=4, y=2 in its third frame.
    directed_at = 2 * htot(cfg[1]) * vtot(cfg[1]) +
                  (cfg[1].vsync + cfg[1].vback + 2) * htot(cfg[1]) +
                  cfg[1].hsync + cfg[1].hback + 4;
    directed_done = 1'b0;
    for (int d = 0; d < 2; d++) begin
      run_valid[d] = 1'b0; ready_cnt[d] = 0; period[d] = 0;
    end

    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) compare(d, -1, observe(d), reset_vals(cfg[d]));
    end
    $display("[TB] reset held 5 clk");

    n = 0;
    for (int i = 0; i < 3000; i++) begin
      rst_v = 1'b0;
      if (!directed_done && n == directed_at + 1) begin
        rst_v = 1'b1;
        directed_done = 1'b1;
      end else if (i > 1200 && $urandom_range(0, 399) == 0) begin
        rst_v = 1'b1;
      end
      rst = rst_v;
      @(posedge clk); #1;
      if (rst_v) begin
        $display("[TB] cycle %0d reset pulse at raster t=%0d", i, n);
        for (int d = 0; d < 2; d++) begin
          compare(d, i, observe(d), reset_vals(cfg[d]));
          run_valid[d] = 1'b0;
        end
        n = 0;
      end else begin
        for (int d = 0; d < 2; d++) begin
          o = observe(d);
          compare(d, i, o, model(cfg[d], n));
          if (o.fs === 1'b1) begin
            if (run_valid[d]) begin
              check($sformatf("d%0d frame_period", d), 32'(period[d]),
                    32'(htot(cfg[d]) * vtot(cfg[d])));
              check($sformatf("d%0d ready_per_frame", d), 32'(ready_cnt[d]),
                    32'(cfg[d].hact * cfg[d].vact));
              $display("[TB] d%0d frame done: period=%0d ready=%0d", d, period[d], ready_cnt[d]);
            end
            run_valid[d] = 1'b1;
            ready_cnt[d] = 0;
            period[d]    = 0;
          end
          period[d]++;
          if (o.rd === 1'b1) ready_cnt[d]++;
        end
        n++;
      end
    end

    check("directed_reset_reached", 32'(directed_done), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
